// File: rtl/remote_btn_pkg.sv
// rtl/remote_btn_pkg.sv - shared types and constants for the remote button conditioner
// REMOTE_BTN_STUCK_DETECT_EN adds the STUCK channel state.
package remote_btn_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    RELEASE_WAIT = 3'd3
`ifdef REMOTE_BTN_STUCK_DETECT_EN
    ,
    STUCK        = 3'd4
`endif
  } btn_state_e;

  localparam int CH_SPACE = 0;
  localparam int CH_ENTER = 1;

  localparam int DEF_DEBOUNCE_CYCLES = 65000;
  localparam int DEF_STUCK_CYCLES    = 130000000;
  localparam int DEF_SYNC_STAGES     = 2;

endpackage

// File: rtl/remote_btn_channel.sv
// rtl/remote_btn_channel.sv - one button channel: synchronizer, debounce FSM, hold counter
// REMOTE_BTN_STUCK_DETECT_EN enables the hold counter and STUCK state.
module remote_btn_channel
  import remote_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic level,
  output logic pulse,
  output logic stuck
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES - 1) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  btn_state_e      state, state_nxt;
  logic [DB_W-1:0] db_cnt, db_cnt_nxt, db_inc;
  logic            held, held_nxt;

  assign held     = (state == PRESSED) || (state == RELEASE_WAIT);
  assign held_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);

`ifdef REMOTE_BTN_STUCK_DETECT_EN
  localparam int HOLD_W = $clog2(STUCK_CYCLES - 1) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STUCK_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;

  // Hold time spans PRESSED and RELEASE_WAIT so release glitches cannot hide a stuck line.
  always_ff @(posedge clk) begin
    if (rst)
      hold_cnt <= '0;
    else if (held && held_nxt && hold_cnt != HOLD_LAST)
      hold_cnt <= hold_cnt + HOLD_W'(1);
    else if (!(held && held_nxt))
      hold_cnt <= '0;
  end
`else
  // Stuck timing only matters when stuck detection is compiled in.
  logic unused_stuck_cfg;
  assign unused_stuck_cfg = (STUCK_CYCLES != 0);
`endif

  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    db_inc     = (db_cnt == DB_LAST) ? db_cnt : db_cnt + DB_W'(1);
    case (state)
      IDLE: begin
        if (synced) begin
          state_nxt  = PRESS_WAIT;
          db_cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!synced)                state_nxt  = IDLE;
        else if (db_cnt == DB_LAST) state_nxt  = PRESSED;
        else                        db_cnt_nxt = db_inc;
      end
      PRESSED: begin
        if (!synced) begin
          state_nxt  = RELEASE_WAIT;
          db_cnt_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (synced)                 state_nxt  = PRESSED;
        else if (db_cnt == DB_LAST) state_nxt  = IDLE;
        else                        db_cnt_nxt = db_inc;
      end
`ifdef REMOTE_BTN_STUCK_DETECT_EN
      STUCK: begin
        if (synced)                 db_cnt_nxt = '0;
        else if (db_cnt == DB_LAST) state_nxt  = IDLE;
        else                        db_cnt_nxt = db_inc;
      end
`endif
      default: state_nxt = IDLE;
    endcase
`ifdef REMOTE_BTN_STUCK_DETECT_EN
    if (held && hold_cnt == HOLD_LAST) begin
      state_nxt  = STUCK;
      db_cnt_nxt = '0;
    end
`endif
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      db_cnt <= '0;
      level  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
      level  <= held_nxt;
      pulse  <= (state == PRESS_WAIT) && (state_nxt == PRESSED);
    end
  end

`ifdef REMOTE_BTN_STUCK_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) stuck <= 1'b0;
    else     stuck <= (state_nxt == STUCK);
  end
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: rtl/remote_btn_cond.sv
// rtl/remote_btn_cond.sv - two independent debounced remote button channels (SPACE, ENTER)
// REMOTE_BTN_STUCK_DETECT_EN enables per-channel stuck detection.
module remote_btn_cond
  import remote_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       space_rx,
  input  logic       enter_rx,
  output logic       space_level,
  output logic       space_pulse,
  output logic       enter_level,
  output logic       enter_pulse,
  output logic [1:0] stuck
);

  remote_btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_space (
    .clk  (clk),
    .rst  (rst),
    .rx   (space_rx),
    .level(space_level),
    .pulse(space_pulse),
    .stuck(stuck[CH_SPACE])
  );

  remote_btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_enter (
    .clk  (clk),
    .rst  (rst),
    .rx   (enter_rx),
    .level(enter_level),
    .pulse(enter_pulse),
    .stuck(stuck[CH_ENTER])
  );

endmodule

// File: tb/tb_remote_btn_cond.sv
// tb/tb_remote_btn_cond.sv - self-checking bench for remote_btn_cond with a pulse scoreboard
module tb_remote_btn_cond;

  localparam int DB   = 8;
  localparam int STK  = 64;
  localparam int SS   = 2;
  localparam int LAT  = SS + DB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       space_rx;
  logic       enter_rx;
  logic       space_level;
  logic       space_pulse;
  logic       enter_level;
  logic       enter_pulse;
  logic [1:0] stuck;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int ch;
    int cyc;
  } pulse_exp_t;

  pulse_exp_t exp_q[$];

  remote_btn_cond #(
    .DEBOUNCE_CYCLES(DB),
    .STUCK_CYCLES   (STK),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .space_rx   (space_rx),
    .enter_rx   (enter_rx),
    .space_level(space_level),
    .space_pulse(space_pulse),
    .enter_level(enter_level),
    .enter_pulse(enter_pulse),
    .stuck      (stuck)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [1:0] p;
    p = {enter_pulse, space_pulse};
    for (int ch = 0; ch < 2; ch++) begin
      if (p[ch]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: ch=%0d at cycle %0d, expected no pulse", ch, cyc);
        end else begin
          pulse_exp_t e;
          e = exp_q.pop_front();
          if (e.ch !== ch || e.cyc !== cyc) begin
            n_fail++;
            $display("FAIL pulse_match: got ch=%0d cycle=%0d, expected ch=%0d cycle=%0d",
                     ch, cyc, e.ch, e.cyc);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_pulse(input int ch, input int at);
    pulse_exp_t e;
    e.ch  = ch;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    space_rx = 1'b0;
    enter_rx = 1'b0;
    tick(3);
    n_checks++;
    if ({space_level, space_pulse, enter_level, enter_pulse, stuck} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_during: outputs=%b expected 000000",
               {space_level, space_pulse, enter_level, enter_pulse, stuck});
    end
    rst = 1'b0;
    tick(3);
    n_checks++;
    if ({space_level, space_pulse, enter_level, enter_pulse, stuck} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_after: outputs=%b expected 000000",
               {space_level, space_pulse, enter_level, enter_pulse, stuck});
    end
  endtask

  task automatic test_space_press();
    int t0, t1;
    t0 = cyc;
    space_rx = 1'b1;
    push_pulse(0, t0 + LAT);
    for (int k = 0; k < LAT + 1; k++) begin
      tick(1);
      n_checks++;
      if (space_level !== (cyc >= t0 + LAT) || enter_level !== 1'b0) begin
        n_fail++;
        $display("FAIL press_level: cycle %0d space_level=%b enter_level=%b expected %b/0",
                 cyc - t0, space_level, enter_level, (cyc >= t0 + LAT));
      end
    end
    t1 = cyc;
    space_rx = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      tick(1);
      n_checks++;
      if (space_level !== (cyc < t1 + LAT)) begin
        n_fail++;
        $display("FAIL release_level: cycle %0d space_level=%b expected %b",
                 cyc - t1, space_level, (cyc < t1 + LAT));
      end
    end
    tick(4);
  endtask

  task automatic test_glitch();
    int t0, t1;
    space_rx = 1'b1;
    tick(5);
    space_rx = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      n_checks++;
      if (space_level !== 1'b0) begin
        n_fail++;
        $display("FAIL press_glitch_level: space_level=%b expected 0", space_level);
      end
    end
    t0 = cyc;
    space_rx = 1'b1;
    push_pulse(0, t0 + LAT);
    tick(LAT + 1);
    space_rx = 1'b0;
    tick(5);
    space_rx = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      n_checks++;
      if (space_level !== 1'b1) begin
        n_fail++;
        $display("FAIL release_glitch_level: space_level=%b expected 1", space_level);
      end
    end
    t1 = cyc;
    space_rx = 1'b0;
    tick(LAT + 1);
    n_checks++;
    if (space_level !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_final_release: space_level=%b expected 0 at %0d", space_level, cyc - t1);
    end
    tick(4);
  endtask

  task automatic test_simultaneous();
    int t0, t1;
    t0 = cyc;
    space_rx = 1'b1;
    enter_rx = 1'b1;
    push_pulse(0, t0 + LAT);
    push_pulse(1, t0 + LAT);
    tick(LAT + 1);
    n_checks++;
    if (space_level !== 1'b1 || enter_level !== 1'b1) begin
      n_fail++;
      $display("FAIL dual_press: levels=%b%b expected 11", space_level, enter_level);
    end
    tick(19);
    t1 = cyc;
    space_rx = 1'b0;
    enter_rx = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      tick(1);
      n_checks++;
      if (space_level !== (cyc < t1 + LAT) || enter_level !== (cyc < t1 + LAT)) begin
        n_fail++;
        $display("FAIL dual_release: cycle %0d levels=%b%b expected %b",
                 cyc - t1, space_level, enter_level, (cyc < t1 + LAT));
      end
    end
    tick(4);
  endtask

  task automatic test_stuck();
    int t0, t1;
    t0 = cyc;
    enter_rx = 1'b1;
    push_pulse(1, t0 + LAT);
`ifdef REMOTE_BTN_STUCK_DETECT_EN
    for (int k = 0; k < 100; k++) begin
      tick(1);
      n_checks++;
      if (enter_level !== (cyc >= t0 + LAT && cyc < t0 + LAT + STK) ||
          stuck !== {(cyc >= t0 + LAT + STK), 1'b0}) begin
        n_fail++;
        $display("FAIL stuck_hold: cycle %0d enter_level=%b stuck=%b expected %b/%b",
                 cyc - t0, enter_level, stuck,
                 (cyc >= t0 + LAT && cyc < t0 + LAT + STK), {(cyc >= t0 + LAT + STK), 1'b0});
      end
    end
    t1 = cyc;
    enter_rx = 1'b0;
    for (int k = 0; k < SS + DB + 2; k++) begin
      tick(1);
      n_checks++;
      if (stuck[1] !== (cyc < t1 + SS + DB) || enter_level !== 1'b0) begin
        n_fail++;
        $display("FAIL stuck_clear: cycle %0d stuck1=%b enter_level=%b expected %b/0",
                 cyc - t1, stuck[1], enter_level, (cyc < t1 + SS + DB));
      end
    end
    t0 = cyc;
    enter_rx = 1'b1;
    push_pulse(1, t0 + LAT);
    tick(LAT + 1);
    n_checks++;
    if (enter_level !== 1'b1 || stuck !== 2'b00) begin
      n_fail++;
      $display("FAIL stuck_repress: enter_level=%b stuck=%b expected 1/00", enter_level, stuck);
    end
`else
    for (int k = 0; k < 100; k++) begin
      tick(1);
      n_checks++;
      if (enter_level !== (cyc >= t0 + LAT) || stuck !== 2'b00) begin
        n_fail++;
        $display("FAIL nostuck_hold: cycle %0d enter_level=%b stuck=%b expected %b/00",
                 cyc - t0, enter_level, stuck, (cyc >= t0 + LAT));
      end
    end
`endif
    t1 = cyc;
    enter_rx = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      tick(1);
      n_checks++;
      if (enter_level !== (cyc < t1 + LAT)) begin
        n_fail++;
        $display("FAIL stuck_release: cycle %0d enter_level=%b expected %b",
                 cyc - t1, enter_level, (cyc < t1 + LAT));
      end
    end
    tick(4);
  endtask

  task automatic test_reset_mid_press();
    int t0, tr, t1;
    t0 = cyc;
    space_rx = 1'b1;
    push_pulse(0, t0 + LAT);
    tick(LAT + 1);
    n_checks++;
    if (space_level !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: space_level=%b expected 1", space_level);
    end
    rst = 1'b1;
    tick(1);
    n_checks++;
    if ({space_level, space_pulse, enter_level, enter_pulse, stuck} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: outputs=%b expected 000000",
               {space_level, space_pulse, enter_level, enter_pulse, stuck});
    end
    rst = 1'b0;
    tr = cyc;
    push_pulse(0, tr + LAT);
    for (int k = 0; k < LAT + 1; k++) begin
      tick(1);
      n_checks++;
      if (space_level !== (cyc >= tr + LAT)) begin
        n_fail++;
        $display("FAIL midreset_requalify: cycle %0d space_level=%b expected %b",
                 cyc - tr, space_level, (cyc >= tr + LAT));
      end
    end
    t1 = cyc;
    space_rx = 1'b0;
    tick(LAT + 1);
    n_checks++;
    if (space_level !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_release: space_level=%b expected 0 at %0d", space_level, cyc - t1);
    end
    tick(4);
  endtask

  initial begin
    rst      = 1'b1;
    space_rx = 1'b0;
    enter_rx = 1'b0;
    test_reset();
    test_space_press();
    test_glitch();
    test_simultaneous();
    test_stuck();
    test_reset_mid_press();
    tick(2);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
